piso_serializer: RTL

Parallel-in serial-out stage that sits directly upstream of the 8-bit SIPO shift register. It accepts a parallel word over a valid/ready handshake and drives it onto a single serial line, one bit per clk rising edge. It also emits per-bit qualifiers (valid, frame start, last) so the downstream SIPO can be checked word-aligned. Back-to-back words stream with no idle cycle between them.

---
 rtl/piso_serializer_pkg.sv | 26 ++
 rtl/piso_serializer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_pkg
//  Description : Shared definitions for the PISO serializer and its SIPO peer:
//                state encoding, the common word width and the bit-counter
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_serializer_pkg;

   // Two-state controller: waiting for a word, or streaming one out.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Word width shared with the downstream 8-bit SIPO stage.
   localparam int SER_WORD_WIDTH = 8;

   // Width of a counter that indexes bits 0..width-1 of a word.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage : piso_serializer_pkg
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in serial-out stage. Accepts a WIDTH-bit word over
//                a valid/ready handshake and emits it one bit per clock with
//                per-bit qualifiers (valid, frame start, last). Back-to-back
//                words stream with no idle cycle in between.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          in   rising-edge clock
//    reset        in   asynchronous, active-low reset
//    din          in   parallel word to serialize (sampled on accept only)
//    din_valid    in   din is presented
//    din_ready    out  word is accepted this cycle if din_valid is high
//    shift_en     in   1 = advance; 0 = freeze and refuse new words
//    sout         out  serial data bit (registered)
//    sout_valid   out  sout carries a live bit (registered)
//    frame_start  out  sout is bit 0 of a word (registered)
//    last         out  sout is bit WIDTH-1 of a word (registered)
//    busy         out  a word is being shifted out
// ============================================================================
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH     = SER_WORD_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             last,
   output logic             busy
);

   localparam int             CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t           state_q,       state_d;
   logic [WIDTH-1:0] sreg_q,        sreg_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic             sout_valid_q,  sout_valid_d;
   logic             frame_start_q, frame_start_d;
   logic             last_q,        last_d;

   logic             cnt_at_last;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;
   logic [WIDTH-1:0] sreg_shifted;
   logic             sreg_out_bit;

   assign cnt_at_last = (cnt_q == CNT_LAST);
   assign cnt_inc     = cnt_q + CNT_ONE;

   // -------------------------------------------------------------------------
   // Bit order. The bit on the line is always the output end of the shift
   // register, so sout comes straight from a flop with no extra stage.
   // -------------------------------------------------------------------------
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
         assign sreg_out_bit = sreg_q[WIDTH-1];
      end else begin : g_lsb_first
         assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
         assign sreg_out_bit = sreg_q[0];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Handshake. A new word can be taken in IDLE, or while the last bit of
   // the current word is on the line so the next word follows without a gap.
   // The reset term keeps ready low for the whole time reset is asserted.
   // -------------------------------------------------------------------------
   assign din_ready = reset & shift_en &
                      ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & cnt_at_last));
   assign accept    = din_valid & din_ready;

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      sreg_d        = sreg_q;
      cnt_d         = cnt_q;
      sout_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      last_d        = 1'b0;

      // With shift_en low everything holds; the qualifiers drop so the frozen
      // bit on sout is not counted again.
      if (shift_en) begin
         if (accept) begin
            state_d       = ST_SHIFT;
            sreg_d        = din;
            cnt_d         = '0;
            sout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
         end else if (state_q == ST_SHIFT) begin
            if (cnt_at_last) begin
               // Word finished with nothing queued: clearing the register
               // also drives sout back to 0.
               state_d = ST_IDLE;
               sreg_d  = '0;
               cnt_d   = '0;
            end else begin
               sreg_d       = sreg_shifted;
               cnt_d        = cnt_inc;
               sout_valid_d = 1'b1;
               last_d       = (cnt_inc == CNT_LAST);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         sreg_q        <= '0;
         cnt_q         <= '0;
         sout_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         last_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sreg_q        <= sreg_d;
         cnt_q         <= cnt_d;
         sout_valid_q  <= sout_valid_d;
         frame_start_q <= frame_start_d;
         last_q        <= last_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign sout        = sreg_out_bit;
   assign sout_valid  = sout_valid_q;
   assign frame_start = frame_start_q;
   assign last        = last_q;
   assign busy        = (state_q == ST_SHIFT);

endmodule : piso_serializer
`default_nettype wire
